// File: rtl/vrp_pkt_arb.sv
// Round-robin, packet-locked arbiter sharing one valid-ready sink among N_REQ requesters.
// Beats are tagged with the source index; packets overrunning MAX_BEATS are force-released.
module vrp_pkt_arb #(
  parameter int N_REQ     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int MAX_BEATS = 16,
  parameter int ID_WIDTH  = $clog2(N_REQ),
  parameter int CNT_WIDTH = $clog2(MAX_BEATS+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           vld_s,
  output logic [N_REQ-1:0]           rdy_s,
  input  logic [N_REQ*PLD_WIDTH-1:0] pld_s,
  input  logic [N_REQ-1:0]           last_s,
  output logic                       vld_m,
  input  logic                       rdy_m,
  output logic [PLD_WIDTH-1:0]       pld_m,
  output logic                       last_m,
  output logic [ID_WIDTH-1:0]        id_m,
  output logic                       err_ovf
);
  // state | meaning
  // IDLE  | no packet open; grant from round-robin scan, or held while the sink stalls
  // LOCK  | packet open; grant fixed to lock_id until its last beat or a forced release
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_FINAL = CNT_WIDTH'(MAX_BEATS-1);
  localparam logic [ID_WIDTH-1:0]  ID_LAST   = ID_WIDTH'(N_REQ-1);

  logic [0:0]           state;
  logic [ID_WIDTH-1:0]  lock_id;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  hold_id;
  logic [ID_WIDTH-1:0]  scan_id;
  logic [ID_WIDTH-1:0]  gnt;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 hold;
  logic                 sel_vld;
  logic                 sel_last;
  logic [PLD_WIDTH-1:0] sel_pld;
  logic                 forced;
  logic                 final_beat;
  logic                 xfer;

  function automatic logic [ID_WIDTH-1:0] inc_mod(input logic [ID_WIDTH-1:0] id);
    return (id == ID_LAST) ? '0 : id + ID_WIDTH'(1);
  endfunction

  // Scan downwards so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    scan_id = rr_ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (vld_s[idx]) scan_id = ID_WIDTH'(idx);
    end
  end

  always_comb begin
    if (state == ST_LOCK) gnt = lock_id;
    else if (hold)        gnt = hold_id;
    else                  gnt = scan_id;
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_pld  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == ID_WIDTH'(i)) begin
        sel_vld  = vld_s[i];
        sel_last = last_s[i];
        sel_pld  = pld_s[i*PLD_WIDTH +: PLD_WIDTH];
      end
    end
  end

  // beat_cnt is zero in IDLE, so with MAX_BEATS=1 every non-last IDLE beat is forced final.
  assign forced     = (beat_cnt == CNT_FINAL) && !sel_last;
  assign final_beat = sel_last || forced;

  assign vld_m  = !rst && sel_vld;
  assign last_m = !rst && final_beat;
  assign id_m   = rst ? '0 : gnt;
  assign pld_m  = sel_pld;
  assign xfer   = vld_m && rdy_m;

  always_comb begin
    rdy_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rdy_s[i] = !rst && rdy_m && (gnt == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_id  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      hold     <= 1'b0;
      hold_id  <= '0;
      err_ovf  <= 1'b0;
    end else if (xfer) begin
      hold <= 1'b0;
      if (final_beat) begin
        state    <= ST_IDLE;
        rr_ptr   <= inc_mod(gnt);
        beat_cnt <= '0;
        if (forced) err_ovf <= 1'b1;
      end else if (state == ST_IDLE) begin
        state    <= ST_LOCK;
        lock_id  <= gnt;
        beat_cnt <= CNT_WIDTH'(1);
      end else begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
    end else if (state == ST_IDLE && vld_m) begin
      hold    <= 1'b1;
      hold_id <= gnt;
    end
  end
endmodule

// File: doc/vrp_pkt_arb.md
# vrp_pkt_arb

Round-robin, packet-locked arbiter that shares one valid-ready sink, normally the write port of a `vrp_fifo`, among N valid-ready requesters. Grants are held from the first beat of a packet through its `last` beat. A beat-count guard force-releases a requester that overruns `MAX_BEATS`. The block sits directly in front of the shared FIFO and tags each beat with its source index so downstream logic can demultiplex.

## Interface
- `N_REQ`, default 4: number of requester ports, ≥2.
- `PLD_WIDTH`, default 32: payload width per beat.
- `MAX_BEATS`, default 16: maximum beats per packet before forced release, ≥1.
- `ID_WIDTH`, default `$clog2(N_REQ)`: width of the source index.
- `CNT_WIDTH`, default `$clog2(MAX_BEATS+1)`: width of the beat counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `vld_s`, in, N_REQ: per-requester valid.
- `rdy_s`, out, N_REQ: per-requester ready.
- `pld_s`, in, N_REQ*PLD_WIDTH: packed payloads; requester i occupies bits [i*PLD_WIDTH +: PLD_WIDTH].
- `last_s`, in, N_REQ: per-requester end-of-packet flag.
- `vld_m`, out, 1: valid to the shared sink.
- `rdy_m`, in, 1: ready from the shared sink.
- `pld_m`, out, PLD_WIDTH: muxed payload.
- `last_m`, out, 1: muxed `last`; also driven high on a forced-release beat.
- `id_m`, out, ID_WIDTH: index of the granted requester.
- `err_ovf`, out, 1: sticky flag for a `MAX_BEATS` overrun.

## Operation
- **State:** `locked` (1 bit), `lock_id` (ID_WIDTH), `rr_ptr` (ID_WIDTH), `beat_cnt` (CNT_WIDTH), `err_ovf`.
- **FSM:** two states.
  - IDLE: `locked=0`.
  - LOCK: `locked=1`.
- **Grant in IDLE:** combinational. Grant goes to the first i with `vld_s[i]=1`, scanning `rr_ptr`, `rr_ptr+1`, … modulo N_REQ.
  - No request: `vld_m=0`, `id_m=rr_ptr`.
- **Grant in LOCK:** fixed to `lock_id` regardless of other requests.
- **Master outputs:**
  - `vld_m = vld_s[gnt]`
  - `pld_m`, `last_m`, `id_m` follow `gnt`
  - `rdy_s[gnt] = rdy_m`; all other `rdy_s` bits are 0.
  - A beat transfers when `vld_m && rdy_m`.
- **Transitions on a transfer:**
  - IDLE, `last_s[gnt]=0`: go to LOCK; `lock_id←gnt`; `beat_cnt←1`.
  - IDLE, `last_s[gnt]=1` (single-beat packet): stay in IDLE; `rr_ptr←gnt+1` mod N_REQ.
  - LOCK, `last_s[lock_id]=1`: go to IDLE; `rr_ptr←lock_id+1`; `beat_cnt←0`.
  - LOCK, `last_s=0`: `beat_cnt←beat_cnt+1`.
- **Forced release:** a transfer in LOCK with `beat_cnt==MAX_BEATS-1` and `last_s=0` is treated as final.
  - `last_m` is forced to 1.
  - FSM goes to IDLE and `rr_ptr` advances.
  - `err_ovf←1`.
  - With MAX_BEATS=1, every non-last IDLE beat is forced-final, sets `err_ovf`, and never enters LOCK.
- **Stalls:** while `vld_m=1 && rdy_m=0`, the grant does not change, including in IDLE.
  - A registered `hold` bit latches the IDLE grant when `vld_m && !rdy_m`, so payload and `id_m` stay stable until the transfer.
- **Wrap-around:** `rr_ptr` increments modulo N_REQ and is not a power-of-two wrap; for N_REQ=3 the sequence is 2→0.
- **`err_ovf`:** cleared only by `rst`.
- **Reset:**
  - While `rst=1`: all `rdy_s=0`, `vld_m=0`, `last_m=0`, `id_m=0`; `pld_m` is don't-care.
  - After reset: `locked=0`, `hold=0`, `rr_ptr=0`, `beat_cnt=0`, `err_ovf=0`.
  - Reset asserted mid-packet drops the lock with no flush and no error.
- **Fairness:** a continuously requesting port is granted within N_REQ-1 packets of other ports.

## Timing
- Zero-cycle datapath: `vld_m`, `pld_m`, `last_m` and `id_m` are combinational from the slave inputs and registered state.
- `rdy_s` is combinational from `rdy_m`.
- No bubble between packets: a new grant can transfer in the cycle after a `last` beat.
- Throughput is one beat per cycle while `rdy_m=1`.
- State updates on the `clk` edge at which the transfer occurs.
- `err_ovf` rises the cycle after the overrun transfer.

## Test plan
- Reset, all four ports requesting single-beat packets, `rdy_m=1` → `id_m` sequence 0,1,2,3,0, one beat per cycle, `err_ovf=0`.
- Port 1 sends a 3-beat packet while port 2 requests → `id_m` stays 1 for 3 transfers, then 2; `rdy_s[2]=0` throughout port 1's packet.
- `rdy_m` low for 5 cycles mid-packet, with a port 0 request rising in IDLE during the stall → `pld_m`/`id_m` are stable and no grant switch occurs until the transfer.
- MAX_BEATS=4, port 3 sends 6 beats with no `last` → beat 4 shows `last_m=1`, `err_ovf=1` the next cycle, and port 0 is granted next if requesting.
- N_REQ=3, only port 2 then port 0 requesting → `rr_ptr` wraps 2→0 and grant order is 2,0; `rst` pulsed mid-packet → all `rdy_s=0` during reset, and port 0 wins first after release.
